// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester round-robin arbiter in front of a single
//                memory controller port. Latches the winner's op/address,
//                routes read beats back, counts beats, and aborts stalled
//                transactions with a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LINE_BEATS     = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [1:0]  r0_op,
  input  logic [63:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rd_valid,
  output logic        r0_done,
  output logic        r0_err,

  input  logic [1:0]  r1_op,
  input  logic [63:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rd_valid,
  output logic        r1_done,
  output logic        r1_err,

  output logic [31:0] rd_data,

  output logic [1:0]  m_op,
  output logic [63:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_tx_done,
  input  logic        m_rd_valid,
  input  logic [31:0] m_rdata,

  output logic [4:0]  beat_count
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  // Abort fires on the edge where the watchdog would reach this value,
  // so a stalled transaction spends TIMEOUT_CYCLES-1 cycles in BUSY.
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]      BEAT_MAX = 5'(LINE_BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t          state;
  logic            owner;     // 0: requester 0 owns the port, 1: requester 1
  logic            last_gnt;  // owner of the most recently finished transaction
  logic [WD_W-1:0] wdog;

  logic            req0;
  logic            req1;
  logic            pick;
  logic            busy;
  logic [WD_W-1:0] wdog_inc;
  logic            timeout;

  // Ops 01 and 11 are requests; 00 (NOP) and 10 (reserved) are not.
  assign req0 = r0_op[0];
  assign req1 = r1_op[0];

  // On contention the requester that did not go last wins.
  assign pick = (req0 && req1) ? ~last_gnt : req1;

  assign busy     = (state == BUSY);
  assign wdog_inc = wdog + 1'b1;
  assign timeout  = (wdog_inc == WD_LAST);

  // Datapath steering: write beat follows the owner live, read beats fan out.
  always_comb begin
    m_wdata     = '0;
    r0_rd_valid = 1'b0;
    r1_rd_valid = 1'b0;
    rd_data     = m_rdata;
    if (busy) begin
      m_wdata     = owner ? r1_wdata : r0_wdata;
      r0_rd_valid = m_rd_valid && !owner;
      r1_rd_valid = m_rd_valid &&  owner;
    end
  end

  // Arbitration FSM with registered grant, command, done and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_gnt   <= 1'b1;
      wdog       <= '0;
      beat_count <= '0;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      r0_done    <= 1'b0;
      r1_done    <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
      m_op       <= 2'b00;
      m_addr     <= '0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      r0_err  <= 1'b0;
      r1_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= BUSY;
            owner      <= pick;
            m_op       <= pick ? r1_op   : r0_op;
            m_addr     <= pick ? r1_addr : r0_addr;
            r0_gnt     <= ~pick;
            r1_gnt     <=  pick;
            wdog       <= '0;
            beat_count <= '0;
          end
        end

        BUSY: begin
          wdog <= wdog_inc;
          if (m_rd_valid && (beat_count != BEAT_MAX)) begin
            beat_count <= beat_count + 5'd1;
          end
          // Completion takes priority over a coincident watchdog expiry.
          if (m_tx_done || timeout) begin
            state    <= TURN;
            last_gnt <= owner;
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            m_op     <= 2'b00;
            m_addr   <= '0;
            if (m_tx_done) begin
              r0_done <= ~owner;
              r1_done <=  owner;
            end else begin
              r0_err  <= ~owner;
              r1_err  <=  owner;
            end
          end
        end

        TURN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. A default
//                instance covers read, write, contention and reset cases;
//                a second instance with an 8-cycle watchdog covers timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  r0_op,  r1_op;
  logic [63:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        m_tx_done, m_rd_valid;
  logic [31:0] m_rdata;

  // default-watchdog instance outputs
  logic        r0_gnt, r0_rd_valid, r0_done, r0_err;
  logic        r1_gnt, r1_rd_valid, r1_done, r1_err;
  logic [31:0] rd_data, m_wdata;
  logic [1:0]  m_op;
  logic [63:0] m_addr;
  logic [4:0]  beat_count;

  // short-watchdog instance outputs
  logic        r0_gnt_t, r0_rd_valid_t, r0_done_t, r0_err_t;
  logic        r1_gnt_t, r1_rd_valid_t, r1_done_t, r1_err_t;
  logic [31:0] rd_data_t, m_wdata_t;
  logic [1:0]  m_op_t;
  logic [63:0] m_addr_t;
  logic [4:0]  beat_count_t;

  int n_checks;
  int n_pass;

  mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .r0_op(r0_op), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rd_valid(r0_rd_valid), .r0_done(r0_done), .r0_err(r0_err),
    .r1_op(r1_op), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rd_valid(r1_rd_valid), .r1_done(r1_done), .r1_err(r1_err),
    .rd_data(rd_data),
    .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_tx_done(m_tx_done), .m_rd_valid(m_rd_valid), .m_rdata(m_rdata),
    .beat_count(beat_count)
  );

  mem_arbiter #(.TIMEOUT_CYCLES(8)) u_dut_to (
    .clk(clk), .rst(rst),
    .r0_op(r0_op), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt_t), .r0_rd_valid(r0_rd_valid_t), .r0_done(r0_done_t), .r0_err(r0_err_t),
    .r1_op(r1_op), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt_t), .r1_rd_valid(r1_rd_valid_t), .r1_done(r1_done_t), .r1_err(r1_err_t),
    .rd_data(rd_data_t),
    .m_op(m_op_t), .m_addr(m_addr_t), .m_wdata(m_wdata_t),
    .m_tx_done(m_tx_done), .m_rd_valid(m_rd_valid), .m_rdata(m_rdata),
    .beat_count(beat_count_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    r0_op      = 2'b00;  r1_op    = 2'b00;
    r0_addr    = '0;     r1_addr  = '0;
    r0_wdata   = '0;     r1_wdata = '0;
    m_tx_done  = 1'b0;   m_rd_valid = 1'b0;
    m_rdata    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rv0, rv1, gnt_cnt, err_cnt;
    n_checks = 0;
    n_pass   = 0;

    // ---------------- reset state ----------------
    do_reset();
    #1;
    check("rst_r0_gnt", r0_gnt, 0);
    check("rst_r1_gnt", r1_gnt, 0);
    check("rst_m_op", m_op, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_done_err", {r0_done, r1_done, r0_err, r1_err}, 0);

    // ---------------- single read, 16 beats ----------------
    @(negedge clk); r0_op = 2'b01; r0_addr = 64'h400; #1;
    check("rd_gnt_before_edge", r0_gnt, 0);
    @(negedge clk); r0_op = 2'b00; #1;
    check("rd_gnt", r0_gnt, 1);
    check("rd_m_op", m_op, 2'b01);
    check("rd_m_addr", m_addr, 64'h400);
    check("rd_bc_start", beat_count, 0);
    rv0 = 0; rv1 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); m_rd_valid = 1'b1; m_rdata = 32'hA000 + i; #1;
      rv0 += int'(r0_rd_valid);
      rv1 += int'(r1_rd_valid);
      if (i == 3) check("rd_data_pass", rd_data, 32'hA003);
    end
    @(negedge clk); m_rd_valid = 1'b0; m_tx_done = 1'b1; #1;
    check("rd_beat_count", beat_count, 16);
    check("rd_r0_valid_cnt", rv0, 16);
    check("rd_r1_valid_cnt", rv1, 0);
    check("rd_done_early", r0_done, 0);
    @(negedge clk); m_tx_done = 1'b0; #1;
    check("rd_done", r0_done, 1);
    check("rd_turn_gnt", r0_gnt, 0);
    check("rd_turn_m_op", m_op, 0);
    check("rd_turn_m_addr", m_addr, 0);
    @(negedge clk); #1;
    check("rd_done_one_cycle", r0_done, 0);

    // ---------------- contention from reset ----------------
    do_reset();
    @(negedge clk); r0_op = 2'b01; r0_addr = 64'h100; r1_op = 2'b11; r1_addr = 64'h200; #1;
    @(negedge clk); m_tx_done = 1'b1; #1;
    check("ct1_r0_gnt", r0_gnt, 1);
    check("ct1_r1_gnt", r1_gnt, 0);
    check("ct1_m_addr", m_addr, 64'h100);
    @(negedge clk); m_tx_done = 1'b0; #1;
    check("ct1_r0_done", r0_done, 1);
    @(negedge clk); #1;
    check("ct_idle_gap_gnt", {r0_gnt, r1_gnt}, 2'b00);
    @(negedge clk); #1;
    check("ct2_r1_gnt", r1_gnt, 1);
    check("ct2_r0_gnt", r0_gnt, 0);
    check("ct2_m_op", m_op, 2'b11);
    check("ct2_m_addr", m_addr, 64'h200);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); m_rd_valid = 1'b1; #1;
      if (i == 0) check("ct2_route", {r0_rd_valid, r1_rd_valid}, 2'b01);
    end
    @(negedge clk); m_rd_valid = 1'b0; m_tx_done = 1'b1; #1;
    check("ct2_bc_saturate", beat_count, 16);
    @(negedge clk); m_tx_done = 1'b0; #1;
    check("ct2_done", {r0_done, r1_done}, 2'b01);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("ct3_r0_gnt", r0_gnt, 1);
    check("ct3_m_op", m_op, 2'b01);

    // ---------------- write passthrough ----------------
    do_reset();
    @(negedge clk); r1_op = 2'b11; r1_addr = 64'h400; r1_wdata = 32'h55; #1;
    check("wr_idle_wdata", m_wdata, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) r1_op = 2'b00;
      r1_wdata = 32'(i); #1;
      if (i == 0) begin
        check("wr_m_op", m_op, 2'b11);
        check("wr_m_addr", m_addr, 64'h400);
      end
      check($sformatf("wr_wdata_%0d", i), m_wdata, 64'(i));
    end
    @(negedge clk); m_tx_done = 1'b1; #1;
    @(negedge clk); m_tx_done = 1'b0; #1;
    check("wr_r1_done", r1_done, 1);
    check("wr_turn_wdata", m_wdata, 0);

    // ---------------- timeout, 8-cycle watchdog ----------------
    do_reset();
    @(negedge clk); r0_op = 2'b01; r0_addr = 64'h800; #1;
    gnt_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); #1;
      gnt_cnt += int'(r0_gnt_t);
      err_cnt += int'(r0_err_t);
    end
    check("to_busy_cycles", gnt_cnt, 7);
    check("to_err_early", err_cnt, 0);
    @(negedge clk); #1;
    check("to_err", r0_err_t, 1);
    check("to_done", r0_done_t, 0);
    check("to_turn_gnt", r0_gnt_t, 0);
    check("to_turn_m_op", m_op_t, 0);
    @(negedge clk); #1;
    check("to_idle_err", r0_err_t, 0);
    check("to_idle_gnt", r0_gnt_t, 0);
    @(negedge clk); #1;
    check("to_regrant", r0_gnt_t, 1);

    // ---------------- done/timeout tie ----------------
    do_reset();
    @(negedge clk); r0_op = 2'b01; #1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) r0_op = 2'b00;
      if (k == 6) m_tx_done = 1'b1;
      #1;
    end
    @(negedge clk); m_tx_done = 1'b0; #1;
    check("tie_done", r0_done_t, 1);
    check("tie_err", r0_err_t, 0);
    @(negedge clk); #1;
    check("tie_err_late", r0_err_t, 0);

    // ---------------- reset mid-BUSY ----------------
    do_reset();
    @(negedge clk); r0_op = 2'b01; r0_addr = 64'h400; r0_wdata = 32'hDEAD; #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) r0_op = 2'b00;
      m_rd_valid = 1'b1; #1;
    end
    @(negedge clk); m_rd_valid = 1'b0; #1;
    check("mr_bc_before", beat_count, 5);
    check("mr_gnt_before", r0_gnt, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("mr_gnt", {r0_gnt, r1_gnt}, 0);
    check("mr_m_op", m_op, 0);
    check("mr_m_addr", m_addr, 0);
    check("mr_m_wdata", m_wdata, 0);
    check("mr_bc", beat_count, 0);
    check("mr_done_err", {r0_done, r1_done, r0_err, r1_err}, 0);
    @(negedge clk); #1;
    check("mr_no_pulse", {r0_done, r1_done, r0_err, r1_err, r0_gnt}, 0);

    // ---------------- controller strobes ignored in IDLE ----------------
    @(negedge clk); m_tx_done = 1'b1; m_rd_valid = 1'b1; #1;
    check("idle_rd_valid", {r0_rd_valid, r1_rd_valid}, 0);
    @(negedge clk); m_tx_done = 1'b0; m_rd_valid = 1'b0; #1;
    check("idle_no_done", {r0_done, r1_done}, 0);
    check("idle_bc", beat_count, 0);

    // ---------------- reserved op is not a request ----------------
    @(negedge clk); r0_op = 2'b10; r1_op = 2'b10; #1;
    @(negedge clk); #1;
    check("rsvd_no_gnt", {r0_gnt, r1_gnt}, 0);
    check("rsvd_m_op", m_op, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum BUSY cycles before a transaction is aborted.
REQ-002 The block SHALL have parameter LINE_BEATS, default 16, giving the number of 32-bit beats per line, used for beat_count saturation.

Interface
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk is the single clock; rst is synchronous and active-high.
REQ-004 The block SHALL provide port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 The block SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL provide port rN_op (N in 0,1), input, 2 bits: requester op, where 00 is NOP, 01 is READ, 11 is WRITE, and 10 is reserved.
REQ-007 The block SHALL provide port rN_addr, input, 64 bits: requester line address.
REQ-008 The block SHALL provide port rN_wdata, input, 32 bits: requester write beat.
REQ-009 The block SHALL provide port rN_gnt, output, 1 bit: requester N owns the memory port.
REQ-010 The block SHALL provide port rN_rd_valid, output, 1 bit: read beat valid for requester N.
REQ-011 The block SHALL provide port rN_done, output, 1 bit: one-cycle pulse when the transaction completes.
REQ-012 The block SHALL provide port rN_err, output, 1 bit: one-cycle pulse when the transaction times out.
REQ-013 The block SHALL provide port rd_data, output, 32 bits: read beat broadcast to both requesters.
REQ-014 The block SHALL provide port m_op, output, 2 bits: op to the memory controller.
REQ-015 The block SHALL provide port m_addr, output, 64 bits: address to the memory controller.
REQ-016 The block SHALL provide port m_wdata, output, 32 bits: write beat to the memory controller.
REQ-017 The block SHALL provide port m_tx_done, input, 1 bit: memory controller transaction complete.
REQ-018 The block SHALL provide port m_rd_valid, input, 1 bit: memory controller read beat valid.
REQ-019 The block SHALL provide port m_rdata, input, 32 bits: memory controller read beat.
REQ-020 The block SHALL provide port beat_count, output, 5 bits: read beats received in the current transaction.

Function
REQ-021 The block SHALL implement exactly three states: IDLE, BUSY and TURN.
REQ-022 A request from requester N SHALL be active when rN_op is 01 or 11; ops 00 and 10 SHALL NOT be requests.
REQ-023 In IDLE, if exactly one request is active, the block SHALL latch that owner's op and addr and enter BUSY on the next edge.
REQ-024 In IDLE with both requests active, the block SHALL grant the requester that is not last_gnt (round-robin).
REQ-025 In IDLE with no active request, the block SHALL remain in IDLE.
REQ-026 Latency: a request seen in IDLE at edge T SHALL give rN_gnt=1 and m_op = latched op in the cycle after T.
REQ-027 In BUSY, m_op and m_addr SHALL be the latched values, and m_wdata SHALL combinationally follow the owner's rN_wdata.
REQ-028 In BUSY, m_rd_valid SHALL be routed to the owner's rN_rd_valid only; the non-owner's rd_valid SHALL stay 0; rd_data SHALL equal m_rdata in all states.
REQ-029 beat_count SHALL clear on entry to BUSY, increment on each m_rd_valid in BUSY, and saturate at LINE_BEATS (16).
REQ-030 m_tx_done in BUSY SHALL pulse the owner's rN_done for exactly 1 cycle (registered, the cycle after), set last_gnt to the owner, and enter TURN.
REQ-031 A watchdog SHALL count BUSY cycles and clear on entry to BUSY.
REQ-032 If the watchdog reaches TIMEOUT_CYCLES-1 without m_tx_done, the block SHALL pulse the owner's rN_err for 1 cycle, set last_gnt to the owner, and enter TURN.
REQ-033 If m_tx_done arrives in the same cycle as the timeout, done SHALL win and err SHALL NOT pulse.
REQ-034 TURN SHALL last exactly 1 cycle with m_op=00, m_addr=0, m_wdata=0 and both gnt low, then return to IDLE.
REQ-035 In IDLE and TURN, m_op SHALL be 00, m_addr SHALL be 0 and m_wdata SHALL be 0.
REQ-036 m_tx_done and m_rd_valid SHALL be ignored outside BUSY.
REQ-037 Changes to the owner's rN_op or rN_addr during BUSY SHALL be ignored, since the latched values are used.
REQ-038 A non-owner request SHALL wait and be evaluated in the next IDLE.
REQ-039 The gap between the owner's done pulse and the next grant SHALL be a minimum of 2 cycles (TURN, IDLE).

Reset
REQ-040 While rst=1 at a clock edge, the block SHALL set state to IDLE and last_gnt to 1, so that r0 wins the first contention.
REQ-041 While rst=1 at a clock edge, the block SHALL clear the watchdog, beat_count, all gnt/done/err/rd_valid outputs, and m_op to 00.
REQ-042 Reset asserted mid-BUSY SHALL abort the transaction without a done or err pulse.

Verification
REQ-043 Bench SHALL cover a single read: r0_op=01, addr=0x400; controller returns 16 m_rd_valid beats then m_tx_done -> r0_gnt the next cycle, 16 r0_rd_valid pulses, beat_count=16, one r0_done pulse, m_op=00 in TURN.
REQ-044 Bench SHALL cover contention from reset: r0 and r1 both request in the same cycle -> r0 is served first, then r1, then r0 again on the next contention.
REQ-045 Bench SHALL cover a write passthrough: r1_op=11, addr=0x400, r1_wdata stepping 0..15 -> m_op=11, m_addr=0x400, m_wdata tracks r1_wdata, and r1_done follows m_tx_done.
REQ-046 Bench SHALL cover timeout: TIMEOUT_CYCLES=8, no m_tx_done -> r0_err pulses once after 7 BUSY cycles, r0_done stays 0, then TURN then IDLE.
REQ-047 Bench SHALL cover a tie: m_tx_done asserted on the timeout cycle -> done pulses and err does not.
REQ-048 Bench SHALL cover reset mid-BUSY after 5 read beats -> all outputs 0 and state IDLE the next cycle, with no done or err pulse.
